// File: rtl/lfsr_step_scheduler.sv
// rtl/lfsr_step_scheduler.sv - frame scheduler that steps and samples eight 8-bit noise LFSRs once per prescaler tick.
// Optional mixer accumulator enabled by `define LFSR_STEP_SCHEDULER_MIX_EN.
module lfsr_step_scheduler #(
  parameter int TICK_DIV = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  key_on,
  input  logic [63:0] lfsr_in,
  output logic [7:0]  lfsr_en,
  output logic [7:0]  sample_out,
  output logic [2:0]  sample_voice,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun,
  output logic [10:0] mix_out,
  output logic        mix_valid
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, STEP, CAPTURE} state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [7:0]    key_q;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [7:0]    cur_byte;

  assign tick     = (cnt == CW'(TICK_DIV - 1));
  assign cur_byte = lfsr_in[{idx, 3'b000} +: 8];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // lfsr_en is loaded on entry to STEP so it is high for exactly the STEP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= 3'd0;
      key_q        <= 8'd0;
      lfsr_en      <= 8'd0;
      sample_out   <= 8'd0;
      sample_voice <= 3'd0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      lfsr_en      <= 8'd0;
      sample_valid <= 1'b0;
      if (tick && state != IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            state <= SCAN;
            idx   <= 3'd0;
            key_q <= key_on;
          end
        end
        SCAN: begin
          if (key_q[idx]) begin
            state   <= STEP;
            lfsr_en <= 8'd1 << idx;
          end else begin
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= IDLE;
          end
        end
        STEP: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          sample_out   <= cur_byte;
          sample_voice <= idx;
          sample_valid <= 1'b1;
          idx          <= idx + 3'd1;
          state        <= (idx == 3'd7) ? IDLE : SCAN;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LFSR_STEP_SCHEDULER_MIX_EN
  logic [10:0] acc;
  logic [10:0] acc_next;
  logic        frame_end;

  // The final capture lands in the same cycle as the frame end, so publish acc_next.
  assign acc_next  = acc + ((state == CAPTURE) ? {3'b000, cur_byte} : 11'd0);
  assign frame_end = ((state == SCAN) && !key_q[idx] && (idx == 3'd7)) ||
                     ((state == CAPTURE) && (idx == 3'd7));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= 11'd0;
      mix_out   <= 11'd0;
      mix_valid <= 1'b0;
    end else begin
      mix_valid <= frame_end;
      if (state == IDLE) begin
        if (tick) acc <= 11'd0;
      end else begin
        acc <= acc_next;
      end
      if (frame_end) mix_out <= acc_next;
    end
  end
`else
  assign mix_out   = 11'd0;
  assign mix_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_step_scheduler.sv
// tb/tb_lfsr_step_scheduler.sv - scoreboard bench for lfsr_step_scheduler with a frame-level reference model.
module tb_lfsr_step_scheduler;
  localparam int TD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  key_on = 8'd0;
  logic [63:0] lfsr_in = 64'd0;
  logic [7:0]  lfsr_en;
  logic [7:0]  sample_out;
  logic [2:0]  sample_voice;
  logic        sample_valid;
  logic        busy;
  logic        overrun;
  logic [10:0] mix_out;
  logic        mix_valid;

  lfsr_step_scheduler #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .key_on(key_on), .lfsr_in(lfsr_in),
    .lfsr_en(lfsr_en), .sample_out(sample_out), .sample_voice(sample_voice),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun),
    .mix_out(mix_out), .mix_valid(mix_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [10:0] sq[$];
  logic [7:0]  eq[$];
  int          mq[$];
  int          e = -1;
  int          fstart = -1;
  int          busy_until = -1;
  bit          exp_ovr = 1'b0;
  logic [7:0]  hold_out = 8'd0;
  logic [2:0]  hold_voice = 3'd0;
  bit          rand_keys = 1'b0;
  bit          rand_lfsr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update for the rising edge that just passed; frames are predicted as whole units.
  task automatic cycle();
    int n;
    int sum;
    @(negedge clk);
    if (rst) begin
      e = -1; fstart = -1; busy_until = -1; exp_ovr = 1'b0;
      hold_out = 8'd0; hold_voice = 3'd0;
      sq.delete(); eq.delete(); mq.delete();
    end else begin
      e++;
      if (e % TD == TD - 1) begin
        if (e <= busy_until) begin
          exp_ovr = 1'b1;
        end else begin
          n = 0; sum = 0; fstart = e;
          for (int i = 0; i < 8; i++) begin
            if (key_on[i]) begin
              n++;
              sum += int'(lfsr_in[8*i +: 8]);
              sq.push_back({3'(i), lfsr_in[8*i +: 8]});
              eq.push_back(8'(1 << i));
            end
          end
          busy_until = e + 8 + 2 * n;
          mq.push_back(sum);
        end
      end
    end
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      cycle();
      if (rand_keys) key_on = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom & $urandom);
      if (rand_lfsr && e >= busy_until) lfsr_in = {$urandom, $urandom};
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin : monitor
    logic [10:0] s;
    forever begin
      @(negedge clk);
      #1;
      chk("busy", busy, (fstart >= 0 && e >= fstart && e < busy_until));
      chk("overrun", overrun, exp_ovr);
      if (lfsr_en != 8'd0) begin
        chk("lfsr_en_onehot", $onehot(lfsr_en), 1);
        if (eq.size() == 0) chk("lfsr_en_unexpected", lfsr_en, 0);
        else chk("lfsr_en", lfsr_en, eq.pop_front());
      end
      if (sample_valid) begin
        if (sq.size() == 0) begin
          chk("sample_valid_unexpected", sample_valid, 0);
        end else begin
          s = sq.pop_front();
          chk("sample_voice", sample_voice, s[10:8]);
          chk("sample_out", sample_out, s[7:0]);
          hold_voice = s[10:8];
          hold_out = s[7:0];
        end
      end else begin
        chk("sample_out_hold", sample_out, hold_out);
        chk("sample_voice_hold", sample_voice, hold_voice);
      end
`ifdef LFSR_STEP_SCHEDULER_MIX_EN
      if (mix_valid) begin
        if (mq.size() == 0) chk("mix_valid_unexpected", mix_valid, 0);
        else chk("mix_out", mix_out, mq.pop_front());
      end
`else
      chk("mix_tied_off", {mix_valid, mix_out}, 0);
`endif
    end
  end

  initial begin : stimulus
    bit found;
    apply_reset();
    key_on = 8'h00;
    run(3 * TD);

    apply_reset();
    key_on = 8'h81;
    lfsr_in = {8'h3C, 48'h1122_3344_5566, 8'hA5};
    run(3 * TD);

    apply_reset();
    key_on = 8'hFF;
    run(4 * TD);

    apply_reset();
    key_on = 8'h03;
    lfsr_in = {48'h0, 16'hFFFF};
    run(2 * TD);

    // Reset landing on the STEP cycle of voice 3 must abort the frame cleanly.
    apply_reset();
    key_on = 8'hFF;
    found = 1'b0;
    for (int c = 0; c < 4 * TD && !found; c++) begin
      run(1);
      if (lfsr_en == 8'h08) found = 1'b1;
    end
    chk("wait_step_voice3", lfsr_en, 8'h08);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(3 * TD);

    for (int r = 0; r < 6; r++) begin
      apply_reset();
      rand_keys = 1'b1;
      rand_lfsr = 1'b1;
      run(400);
    end
    rand_keys = 1'b0;
    key_on = 8'h00;
    run(3 * TD);
    chk("sample_queue_drained", sq.size(), 0);
    chk("lfsr_en_queue_drained", eq.size(), 0);
`ifdef LFSR_STEP_SCHEDULER_MIX_EN
    chk("mix_queue_drained", mq.size(), 0);
`endif
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
